// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: fetch PC, word-organised instruction memory with a
// program port, and registered instr/pc_out with stall and redirect handling.
module mips_fetch_unit #(
   parameter int unsigned MEM_WORDS = 64,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        prog_we,
   input  logic [31:0] prog_addr,
   input  logic [31:0] prog_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr,
   output logic [31:0] pc_out,
   output logic        instr_valid,
   output logic        fetch_err
);

   localparam int unsigned AW = $clog2(MEM_WORDS);

   typedef enum logic {
      BOOT,
      RUN
   } state_t;

   state_t      state;
   logic [31:0] mem [MEM_WORDS];
   logic [31:0] fetch_pc;
   logic [AW-1:0] fetch_idx;
   logic [AW-1:0] prog_idx;
   logic        fetch_in_range;
   logic        prog_in_range;
   logic        target_misaligned;
   logic [31:0] target_pc;
   logic [31:0] rd_word;

   always_comb begin
      fetch_idx         = fetch_pc[AW+1:2];
      prog_idx          = prog_addr[AW+1:2];
      fetch_in_range    = (fetch_pc[31:AW+2] == '0);
      prog_in_range     = (prog_addr[31:AW+2] == '0);
      target_misaligned = |redirect_pc[1:0];
      target_pc         = {redirect_pc[31:2], 2'b00};
      rd_word           = mem[fetch_idx];
   end

   // No reset on the array: contents survive rst_n and writes land during reset.
   // Addresses beyond the memory are dropped rather than aliased onto it.
   always_ff @(posedge clk) begin
      if (prog_we && prog_in_range) begin
         mem[prog_idx] <= prog_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= BOOT;
         fetch_pc    <= RESET_PC;
         instr       <= '0;
         pc_out      <= RESET_PC;
         instr_valid <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               state <= RUN;
               if (redirect) begin
                  fetch_pc <= target_pc;
                  if (target_misaligned) begin
                     fetch_err <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (redirect) begin
                  instr       <= '0;
                  instr_valid <= 1'b0;
                  fetch_pc    <= target_pc;
                  if (target_misaligned) begin
                     fetch_err <= 1'b1;
                  end
               end else if (!stall) begin
                  instr       <= fetch_in_range ? rd_word : '0;
                  pc_out      <= fetch_pc;
                  instr_valid <= 1'b1;
                  fetch_pc    <= fetch_pc + 32'd4;
                  if (!fetch_in_range) begin
                     fetch_err <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the fetch stage.
module tb_mips_fetch_unit;

   localparam int MW = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        prog_we;
   logic [31:0] prog_addr;
   logic [31:0] prog_data;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instr;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        fetch_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mips_fetch_unit #(
      .MEM_WORDS(MW),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .instr      (instr),
      .pc_out     (pc_out),
      .instr_valid(instr_valid),
      .fetch_err  (fetch_err)
   );

   // Behavioural model: what the stage should present after each edge.
   logic [31:0] m_mem [MW];
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pc_out;
   logic        m_valid;
   logic        m_err;
   bit          m_boot;

   // Advance model with the inputs currently driven, then clock the DUT.
   task automatic tick();
      if (!rst_n) begin
         m_pc = 0; m_boot = 1; m_instr = 0; m_pc_out = 0; m_valid = 0; m_err = 0;
      end else if (m_boot || redirect) begin
         if (!m_boot) begin
            m_instr = 0;
            m_valid = 0;
         end
         m_boot = 0;
         if (redirect) begin
            m_pc = redirect_pc - (redirect_pc % 4);
            if (redirect_pc % 4 != 0) m_err = 1;
         end
      end else if (!stall) begin
         if (m_pc >= MW * 4) begin
            m_instr = 0;
            m_err   = 1;
         end else begin
            m_instr = m_mem[m_pc / 4];
         end
         m_pc_out = m_pc;
         m_valid  = 1;
         m_pc     = m_pc + 4;
      end
      if (prog_we && prog_addr < MW * 4) m_mem[prog_addr / 4] = prog_data;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      prog_we = 0; prog_addr = 0; prog_data = 0;
      stall = 0; redirect = 0; redirect_pc = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      for (int i = 0; i < MW; i++) begin
         prog_we   = 1;
         prog_addr = i * 4 + ($urandom % 4);
         case (i)
            0:       prog_data = 32'h0109_8020;
            1:       prog_data = 32'h014B_8822;
            2:       prog_data = 32'h018D_9024;
            8:       prog_data = 32'hADC9_0000;
            default: prog_data = $urandom;
         endcase
         tick();
      end
      idle_inputs();
      tick();
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=%h", instr, 32'h0); end
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out got=%h exp=%h", pc_out, 32'h0); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", fetch_err); end
   endtask

   task automatic test_sequence();
      rst_n = 1;
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got=%b exp=0", instr_valid); end
      tick();
      checks++; if (pc_out !== 32'h0 || instr !== 32'h0109_8020 || instr_valid !== 1'b1) begin
         errors++; $display("FAIL seq0 got pc=%h instr=%h v=%b exp pc=0 instr=01098020 v=1", pc_out, instr, instr_valid);
      end
      tick();
      checks++; if (pc_out !== 32'h4 || instr !== 32'h014B_8822 || instr_valid !== 1'b1) begin
         errors++; $display("FAIL seq4 got pc=%h instr=%h v=%b exp pc=4 instr=014b8822 v=1", pc_out, instr, instr_valid);
      end
   endtask

   task automatic test_stall();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (pc_out !== 32'h4 || instr !== 32'h014B_8822 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold[%0d] got pc=%h instr=%h v=%b exp pc=4 instr=014b8822 v=1", i, pc_out, instr, instr_valid);
         end
      end
      stall = 0;
      tick();
      checks++; if (pc_out !== 32'h8 || instr !== 32'h018D_9024) begin
         errors++; $display("FAIL stall_release got pc=%h instr=%h exp pc=8 instr=018d9024", pc_out, instr);
      end
   endtask

   task automatic test_redirect();
      stall = 1; redirect = 1; redirect_pc = 32'h20;
      tick();
      checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || pc_out !== 32'h8) begin
         errors++; $display("FAIL redirect_bubble got v=%b instr=%h pc=%h exp v=0 instr=0 pc=8", instr_valid, instr, pc_out);
      end
      stall = 0; redirect = 0;
      tick();
      checks++; if (pc_out !== 32'h20 || instr !== 32'hADC9_0000 || instr_valid !== 1'b1) begin
         errors++; $display("FAIL redirect_target got pc=%h instr=%h v=%b exp pc=20 instr=adc90000 v=1", pc_out, instr, instr_valid);
      end
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL redirect_aligned_err got=%b exp=0", fetch_err); end
   endtask

   task automatic test_misaligned();
      redirect = 1; redirect_pc = 32'h22;
      tick();
      checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL misalign_err got=%b exp=1", fetch_err); end
      redirect = 0;
      tick();
      checks++; if (pc_out !== 32'h20 || instr !== 32'hADC9_0000) begin
         errors++; $display("FAIL misalign_fetch got pc=%h instr=%h exp pc=20 instr=adc90000", pc_out, instr);
      end
      repeat (4) tick();
      checks++; if (fetch_err !== 1'b1 || pc_out !== 32'h30) begin
         errors++; $display("FAIL misalign_sticky got err=%b pc=%h exp err=1 pc=30", fetch_err, pc_out);
      end
   endtask

   task automatic test_out_of_range();
      idle_inputs();
      rst_n = 0;
      tick();
      rst_n = 1;
      tick();
      redirect = 1; redirect_pc = 32'h100;
      tick();
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL oor_pre_err got=%b exp=0", fetch_err); end
      redirect = 0;
      tick();
      checks++; if (pc_out !== 32'h100 || instr !== 32'h0 || instr_valid !== 1'b1 || fetch_err !== 1'b1) begin
         errors++; $display("FAIL oor_fetch got pc=%h instr=%h v=%b err=%b exp pc=100 instr=0 v=1 err=1", pc_out, instr, instr_valid, fetch_err);
      end
   endtask

   task automatic test_reset_midrun();
      int budget;
      idle_inputs();
      rst_n = 0;
      tick();
      rst_n = 1;
      budget = 0;
      while (pc_out !== 32'h10 && budget < 20) begin
         tick();
         budget++;
      end
      checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL midrun_reach got pc=%h exp=10", pc_out); end
      stall = 1; redirect = 1; redirect_pc = 32'h40; rst_n = 0;
      tick();
      checks++; if (pc_out !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
         errors++; $display("FAIL midrun_reset got pc=%h instr=%h v=%b err=%b exp all 0", pc_out, instr, instr_valid, fetch_err);
      end
      idle_inputs();
      rst_n = 1;
      tick();
      tick();
      checks++; if (pc_out !== 32'h0 || instr !== 32'h0109_8020 || instr_valid !== 1'b1) begin
         errors++; $display("FAIL midrun_restart got pc=%h instr=%h v=%b exp pc=0 instr=01098020 v=1", pc_out, instr, instr_valid);
      end
   endtask

   task automatic test_random();
      idle_inputs();
      rst_n = 0;
      tick();
      rst_n = 1;
      for (int c = 0; c < 400; c++) begin
         stall       = ($urandom % 10) < 3;
         redirect    = ($urandom % 10) == 0;
         redirect_pc = $urandom_range(0, MW * 4 + 12);
         if ($urandom % 4 != 0) redirect_pc[1:0] = 2'b00;
         prog_we     = ($urandom % 5) == 0;
         prog_addr   = $urandom_range(0, MW * 4 + 12);
         prog_data   = $urandom;
         // Occasionally hit the word being fetched to exercise read-before-write.
         if (prog_we && ($urandom % 3) == 0) prog_addr = m_pc;
         tick();
         checks++; if (instr !== m_instr || pc_out !== m_pc_out || instr_valid !== m_valid || fetch_err !== m_err) begin
            errors++;
            $display("FAIL random[%0d] got pc=%h instr=%h v=%b err=%b exp pc=%h instr=%h v=%b err=%b",
                     c, pc_out, instr, instr_valid, fetch_err, m_pc_out, m_instr, m_valid, m_err);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_stall();
      test_redirect();
      test_misaligned();
      test_out_of_range();
      test_reset_midrun();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of mips_processor. Holds the fetch PC and a word-organised instruction memory, and presents one instruction per cycle with its PC on instr/pc_out. Supports stall from the core and PC redirect for taken branches and jumps (with one-bubble flush). Memory is loaded through a program port, so benches no longer index a memory array with pc_out themselves.

Parameters:
MEM_WORDS, 64, instruction memory depth in 32-bit words (power of 2, ≥4)
RESET_PC, 32'h0000_0000, fetch PC after reset (word aligned)

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  reset, synchronous, active-low
prog_we  input  1  write prog_data into memory at prog_addr this cycle
prog_addr  input  32  byte address of word to program; bits [1:0] ignored
prog_data  input  32  instruction word to program
stall  input  1  core cannot accept; hold fetch outputs and PC
redirect  input  1  taken branch/jump; next fetch from redirect_pc
redirect_pc  input  32  byte target address
instr  output  32  fetched instruction word (registered)
pc_out  output  32  byte address of the word currently on instr (registered)
instr_valid  output  1  instr/pc_out hold a real instruction
fetch_err  output  1  sticky: misaligned redirect or out-of-range fetch seen

Behaviour:
- Internal registers: fetch_pc (32), state (BOOT, RUN), outputs instr, pc_out, instr_valid, fetch_err.
- Reset (rst_n=0 at a rising edge): fetch_pc=RESET_PC, state=BOOT, instr=32'h0, pc_out=RESET_PC, instr_valid=0, fetch_err=0. Memory contents are NOT cleared. prog_we is honoured during reset.
- BOOT: one cycle with instr_valid=0, then unconditionally to RUN. stall/redirect are ignored in BOOT except redirect loads fetch_pc.
- RUN, priority per cycle: redirect > stall > normal.
  - Normal: instr<=mem[fetch_pc idx], pc_out<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+4. Latency: address to instr is 1 cycle.
  - Stall (redirect=0): instr, pc_out, instr_valid, fetch_pc all hold.
  - Redirect (stall ignored): instr<=32'h0 (NOP), instr_valid<=0, pc_out holds, fetch_pc<=redirect_pc with bits[1:0] forced to 0. The target word appears on instr the following cycle (one bubble).
- Index = fetch_pc[log2(MEM_WORDS)+1:2]. If fetch_pc ≥ MEM_WORDS*4, the fetch returns 32'h0 with instr_valid=1 and sets fetch_err.
- Redirect with redirect_pc[1:0]≠0 sets fetch_err. fetch_err clears only on reset.
- fetch_pc+4 wraps modulo 2^32; no saturation.
- Memory write is synchronous. If the same word is written and fetched in one cycle, the fetch returns the old contents (read-before-write).
- Reset asserted mid-run overrides stall and redirect in that cycle.

Test Plan:
- Program mem[0]=0x01098020, mem[4]=0x014B8822, mem[8]=0x018D9024 under reset, then release -> first edge instr_valid=0, then (pc_out,instr)=(0,0x01098020), (4,0x014B8822), (8,0x018D9024) on consecutive cycles.
- Stall for 3 cycles while pc_out=4 -> pc_out=4, instr=0x014B8822, instr_valid=1 held for 3 cycles; cycle after release pc_out=8.
- stall=1 and redirect=1 with redirect_pc=0x20, mem[0x20]=0xADC90000 -> next cycle instr_valid=0, instr=0; following cycle pc_out=0x20, instr=0xADC90000.
- Redirect to 0x22 -> fetch from 0x20, fetch_err=1, and it stays 1 after later normal fetches until rst_n=0.
- MEM_WORDS=64, redirect to 0x100 -> pc_out=0x100, instr=0, instr_valid=1, fetch_err=1.
- Assert rst_n=0 for one cycle at pc_out=0x10 while stall=1 -> outputs return to reset values, memory still holds mem[0]=0x01098020, and the fetch sequence restarts at 0.
